// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined multiply-accumulate over one convolution window.
// Stage 0 registers the tap products. TREE_DEPTH registered adder levels reduce them.
// A final stage adds the bias and applies an optional ReLU.
// A single valid bit per stage travels alongside the data, and an output stall freezes the whole pipe.
module conv_mac_pipe #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int SIGNED      = 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         pipe_flush_i,
  input  logic                                         in_valid_i,
  output logic                                         in_ready_o,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] kernel_data_i,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] filter_data_i,
  input  logic [ACC_WIDTH-1:0]                         bias_i,
  input  logic                                         relu_en_i,
  output logic                                         out_valid_o,
  input  logic                                         out_ready_i,
  output logic [ACC_WIDTH-1:0]                         conv_data_o
);

  localparam int N          = KERNEL_SIZE * KERNEL_SIZE;
  localparam int TREE_DEPTH = $clog2(N);
  localparam int LATENCY    = TREE_DEPTH + 2;

  // Each tree level has one spare slot (index N) so that the odd-leftover pairing never indexes past the array.
  logic [ACC_WIDTH-1:0] lvl    [0:TREE_DEPTH][0:N];
  logic [ACC_WIDTH-1:0] bias_q [0:TREE_DEPTH];
  logic                 relu_q [0:TREE_DEPTH];
  logic [ACC_WIDTH-1:0] prod   [0:N-1];
  logic [ACC_WIDTH-1:0] out_data_q;
  logic [ACC_WIDTH-1:0] final_sum;
  logic [ACC_WIDTH-1:0] final_result;
  logic [LATENCY-1:0]   valid_q;
  logic                 stall;

  // Number of live terms at a given tree level: ceil(N / 2^level).
  function automatic int level_count(input int level);
    return (N + (1 << level) - 1) >> level;
  endfunction

  // Widen an operand to ACC_WIDTH bits: sign-extend in signed mode, zero-extend otherwise.
  function automatic logic [ACC_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v);
    logic fill;
    fill = (SIGNED != 0) && v[DATA_WIDTH-1];
    return {{(ACC_WIDTH-DATA_WIDTH){fill}}, v};
  endfunction

  // The output handshake is masked during reset, so the reported state is clean before the first reset edge.
  assign out_valid_o = valid_q[LATENCY-1] & ~rst;
  assign conv_data_o = rst ? '0 : out_data_q;
  assign stall       = out_valid_o & ~out_ready_i;
  assign in_ready_o  = ~stall;

  // Per-tap products are computed on the extended operands, so the ACC_WIDTH product wraps correctly.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      prod[j] = extend(kernel_data_i[j*DATA_WIDTH +: DATA_WIDTH]) *
                extend(filter_data_i[j*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Final stage arithmetic: add the bias, and clamp negative sums to zero when ReLU is requested.
  always_comb begin
    final_sum    = lvl[TREE_DEPTH][0] + bias_q[TREE_DEPTH];
    final_result = final_sum;
    if ((SIGNED != 0) && relu_q[TREE_DEPTH] && final_sum[ACC_WIDTH-1]) begin
      final_result = '0;
    end
  end

  // Datapath registers (products, adder tree, bias/ReLU stage) all advance together unless stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l <= TREE_DEPTH; l++) begin
        for (int i = 0; i <= N; i++) begin
          lvl[l][i] <= '0;
        end
        bias_q[l] <= '0;
        relu_q[l] <= 1'b0;
      end
      out_data_q <= '0;
    end else if (!stall) begin
      for (int j = 0; j < N; j++) begin
        lvl[0][j] <= prod[j];
      end
      lvl[0][N] <= '0;
      bias_q[0] <= bias_i;
      relu_q[0] <= relu_en_i;
      for (int l = 1; l <= TREE_DEPTH; l++) begin
        for (int i = 0; i < (N + 1) / 2; i++) begin
          if (2 * i + 1 < level_count(l - 1)) begin
            lvl[l][i] <= lvl[l-1][2*i] + lvl[l-1][2*i+1];
          end else if (2 * i < level_count(l - 1)) begin
            lvl[l][i] <= lvl[l-1][2*i];
          end else begin
            lvl[l][i] <= '0;
          end
        end
        for (int i = (N + 1) / 2; i <= N; i++) begin
          lvl[l][i] <= '0;
        end
        bias_q[l] <= bias_q[l-1];
        relu_q[l] <= relu_q[l-1];
      end
      out_data_q <= final_result;
    end
  end

  // Valid bits: reset and flush wipe them (flush wins over stall); otherwise they shift in lockstep with the data.
  always_ff @(posedge clk) begin
    if (rst || pipe_flush_i) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q <= {valid_q[LATENCY-2:0], in_valid_i};
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb_conv_mac_pipe: four conv_mac_pipe instances share one stimulus bus.
// The instances are: dut0 = K3 unsigned, dut1 = K3 signed, dut2 = K1 signed, dut3 = K5 signed.
// Each accepted transfer queues its expected result, and a monitor retires the queue as results appear.
module tb_conv_mac_pipe;

  localparam int ND = 4;

  typedef struct {
    int          d;
    logic [31:0] val;
    int          due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              out_ready = 1'b1;
  logic              relu = 1'b0;
  logic [31:0]       bias = '0;
  logic [199:0]      kdat = '0;
  logic [199:0]      fdat = '0;
  logic [ND-1:0]     in_valid = '0;
  logic [ND-1:0]     in_ready;
  logic [ND-1:0]     out_valid;
  logic [31:0]       conv [ND];

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Free-running cycle count, advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  conv_mac_pipe #(.KERNEL_SIZE(3), .SIGNED(0)) dut0 (
    .clk(clk), .rst(rst), .pipe_flush_i(flush), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .kernel_data_i(kdat[71:0]), .filter_data_i(fdat[71:0]), .bias_i(bias), .relu_en_i(relu),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .conv_data_o(conv[0]));

  conv_mac_pipe #(.KERNEL_SIZE(3), .SIGNED(1)) dut1 (
    .clk(clk), .rst(rst), .pipe_flush_i(flush), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .kernel_data_i(kdat[71:0]), .filter_data_i(fdat[71:0]), .bias_i(bias), .relu_en_i(relu),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .conv_data_o(conv[1]));

  conv_mac_pipe #(.KERNEL_SIZE(1), .SIGNED(1)) dut2 (
    .clk(clk), .rst(rst), .pipe_flush_i(flush), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .kernel_data_i(kdat[7:0]), .filter_data_i(fdat[7:0]), .bias_i(bias), .relu_en_i(relu),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready), .conv_data_o(conv[2]));

  conv_mac_pipe #(.KERNEL_SIZE(5), .SIGNED(1)) dut3 (
    .clk(clk), .rst(rst), .pipe_flush_i(flush), .in_valid_i(in_valid[3]), .in_ready_o(in_ready[3]),
    .kernel_data_i(kdat[199:0]), .filter_data_i(fdat[199:0]), .bias_i(bias), .relu_en_i(relu),
    .out_valid_o(out_valid[3]), .out_ready_i(out_ready), .conv_data_o(conv[3]));

  // Pipeline latency of each instance: K3 -> 6, K1 -> 2, K5 -> 7.
  function automatic int lat_of(input int d);
    if (d == 2) return 2;
    if (d == 3) return 7;
    return 6;
  endfunction

  // Fill the first n byte lanes with the same value.
  function automatic logic [199:0] rep(input logic [7:0] v, input int n);
    logic [199:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[j*8 +: 8] = v;
    return r;
  endfunction

  // Signed reference: exact 64-bit sum, wrapped to 32 bits, then ReLU.
  function automatic logic [31:0] model(input logic [199:0] k, input logic [199:0] f, input int n,
                                        input logic [31:0] b, input logic r);
    longint      s;
    logic [31:0] res;
    s = longint'($signed(b));
    for (int j = 0; j < n; j++)
      s += longint'($signed(k[j*8 +: 8])) * longint'($signed(f[j*8 +: 8]));
    res = s[31:0];
    if (r && res[31]) res = '0;
    return res;
  endfunction

  task automatic checkOutput(input string name, input int d, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("[TB] FAIL %s dut%0d: got 0x%08h (%0d), expected 0x%08h (%0d)", name, d, act, act, exp_v, exp_v);
  endtask

  // Drive one offer in the current cycle (caller is already at the falling edge) and queue its result if it will be taken.
  task automatic applyStimulus(input int d, input logic [199:0] k, input logic [199:0] f, input logic [31:0] b,
                               input logic r, input logic [31:0] e, input bit timed, input bit keep, output bit acc);
    exp_t item;
    kdat = k; fdat = f; bias = b; relu = r;
    in_valid = '0;
    in_valid[d] = 1'b1;
    #1;
    acc = in_ready[d] && !flush && !rst;
    if (acc && keep) begin
      item.d = d;
      item.val = e;
      item.due = timed ? cyc + lat_of(d) : -1;
      sb.push_back(item);
    end
  endtask

  task automatic sendOne(input int d, input logic [199:0] k, input logic [199:0] f, input logic [31:0] b,
                         input logic r, input logic [31:0] e);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      flush = 1'b0;
      applyStimulus(d, k, f, b, r, e, 1'b1, 1'b1, acc);
      n++;
    end
    if (!acc) checkOutput("accept_timeout", d, 32'(acc), 32'd1);
  endtask

  // Go idle and wait, within a bound, for every queued result to appear; then linger to catch stray outputs.
  task automatic drain(input int maxc);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = '0;
    flush = 1'b0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", -1, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: any presented result must match the oldest expectation for that instance, and it retires on handshake.
  always begin : monitor
    int idx;
    @(negedge clk);
    #2;
    for (int d = 0; d < ND; d++) begin
      if (out_valid[d]) begin
        idx = -1;
        foreach (sb[k]) if (idx < 0 && sb[k].d == d) idx = k;
        if (idx < 0) begin
          checkOutput("unexpected_valid", d, 32'd1, 32'd0);
        end else begin
          checkOutput("conv_data", d, conv[d], sb[idx].val);
          if (out_ready) begin
            if (sb[idx].due >= 0) checkOutput("latency", d, 32'(cyc), 32'(sb[idx].due));
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    bit           acc;
    int           sent;
    logic [199:0] k, f;
    logic [31:0]  b;
    logic         r;
    int           nt;

    // Reset state of every instance.
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checkOutput("rst_out_valid", d, 32'(out_valid[d]), 32'd0);
      checkOutput("rst_conv_data", d, conv[d], 32'd0);
      checkOutput("rst_in_ready", d, 32'(in_ready[d]), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] unsigned K3 directed vectors");
    sendOne(0, rep(8'd1, 9), rep(8'd2, 9), 32'd5, 1'b0, 32'd23);
    drain(20);
    sendOne(0, rep(8'hFF, 9), rep(8'hFF, 9), 32'd0, 1'b1, 32'd585225);
    drain(20);

    $display("[TB] signed K3 directed vectors");
    sendOne(1, rep(8'd127, 9), rep(8'hFF, 9), 32'd0, 1'b0, 32'hFFFF_FB89);
    sendOne(1, rep(8'd127, 9), rep(8'hFF, 9), 32'd0, 1'b1, 32'd0);
    sendOne(1, rep(8'd127, 9), rep(8'd1, 9), 32'hFFFF_FF9C, 1'b1, 32'd1043);
    sendOne(1, rep(8'd127, 9), rep(8'hFF, 9), 32'd2000, 1'b1, 32'd857);
    sendOne(1, rep(8'h80, 9), rep(8'h80, 9), 32'd0, 1'b0, 32'd147456);
    sendOne(1, rep(8'd127, 9), rep(8'd1, 9), 32'h7FFF_FFFF, 1'b0, 32'h8000_0476);
    drain(30);

    $display("[TB] back-to-back stream with a three-cycle output stall");
    sent = 0;
    for (int t = 0; t < 40 && sent < 10; t++) begin
      @(negedge clk);
      out_ready = !(t >= 8 && t < 11);
      applyStimulus(1, rep(8'(sent + 1), 9), rep(8'd2, 9), 32'(sent), 1'b0,
                    32'(18 * (sent + 1) + sent), 1'b0, 1'b1, acc);
      checkOutput("in_ready_stall", 1, 32'(in_ready[1]), 32'(!(t >= 8 && t < 11)));
      if (acc) sent++;
    end
    out_ready = 1'b1;
    drain(40);

    $display("[TB] flush with three transfers in flight");
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      applyStimulus(1, rep(8'(t + 3), 9), rep(8'd1, 9), 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, acc);
      checkOutput("flush_setup_accept", 1, 32'(acc), 32'd1);
    end
    @(negedge clk);
    in_valid = '0;
    @(negedge clk);
    flush = 1'b1;
    applyStimulus(1, rep(8'd9, 9), rep(8'd9, 9), 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, acc);
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1, rep(8'd4, 9), rep(8'd3, 9), 32'd7, 1'b0, 32'd115, 1'b1, 1'b1, acc);
    checkOutput("post_flush_accept", 1, 32'(acc), 32'd1);
    drain(30);

    $display("[TB] reset with four transfers in flight");
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      applyStimulus(1, rep(8'd5, 9), rep(8'd5, 9), 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, acc);
      checkOutput("rst_setup_accept", 1, 32'(acc), 32'd1);
    end
    @(negedge clk);
    in_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_valid", 1, 32'(out_valid[1]), 32'd0);
    checkOutput("rst_mid_data", 1, conv[1], 32'd0);
    checkOutput("rst_mid_ready", 1, 32'(in_ready[1]), 32'd1);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    sendOne(1, rep(8'd2, 9), rep(8'd3, 9), 32'd1, 1'b0, 32'd55);
    drain(30);

    $display("[TB] K1 and K5 instances: most-negative products and random bursts");
    for (int d = 2; d <= 3; d++) begin
      nt = (d == 2) ? 1 : 25;
      sendOne(d, rep(8'h80, nt), rep(8'h80, nt), 32'd0, 1'b0, (d == 2) ? 32'd16384 : 32'd409600);
      for (int i = 0; i < 8; i++) begin
        k = '0;
        f = '0;
        for (int j = 0; j < nt; j++) begin
          k[j*8 +: 8] = 8'($urandom);
          f[j*8 +: 8] = 8'($urandom);
          if ($urandom_range(3) == 0) begin
            k[j*8 +: 8] = 8'h80;
            f[j*8 +: 8] = 8'h80;
          end
        end
        b = $urandom;
        r = 1'($urandom_range(1));
        @(negedge clk);
        applyStimulus(d, k, f, b, r, model(k, f, nt, b, r), 1'b1, 1'b1, acc);
        checkOutput("burst_accept", d, 32'(acc), 32'd1);
      end
      drain(40);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
